// File: rtl/shift_add_multiplier.sv
// Sequential unsigned shift-and-add multiplier: one partial product per clock over xlen RUN cycles.
// Optional zero-operand shortcut enabled by defining MULT_ZERO_SKIP_EN.

module ripple_carry_adder #(
    parameter int width = 4
) (
    input  logic [width-1:0] i_a,
    input  logic [width-1:0] i_b,
    input  logic             i_cin,
    output logic [width-1:0] o_sum,
    output logic             o_cout
);

    logic [width:0] w_c;

    assign w_c[0] = i_cin;

    for (genvar gi = 0; gi < width; gi++) begin : g_fa
        assign o_sum[gi]  = i_a[gi] ^ i_b[gi] ^ w_c[gi];
        assign w_c[gi+1]  = (i_a[gi] & i_b[gi]) | (w_c[gi] & (i_a[gi] ^ i_b[gi]));
    end

    assign o_cout = w_c[width];

endmodule

module shift_add_multiplier #(
    parameter int xlen = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [xlen-1:0]   a,
    input  logic [xlen-1:0]   b,
    output logic              ready,
    output logic              done,
    output logic [2*xlen-1:0] product
);

    localparam int CW = (xlen > 1) ? $clog2(xlen) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [xlen-1:0] r_mcand;
    logic [xlen-1:0] r_hi;
    logic [xlen-1:0] r_lo;
    logic [CW-1:0]   r_cnt;

    logic [xlen-1:0] w_add_sum;
    logic            w_add_cout;
    logic [xlen-1:0] w_sum_sel;
    logic            w_cout_sel;
    logic [xlen-1:0] w_hi_next;
    logic [xlen-1:0] w_lo_next;
    logic            w_zero;
    logic            w_accept;
    logic            w_last;

`ifdef MULT_ZERO_SKIP_EN
    assign w_zero = (a == '0) || (b == '0);
`else
    assign w_zero = 1'b0;
`endif

    assign w_accept = (r_state == ST_IDLE) && start;
    assign w_last   = (r_cnt == CW'(xlen - 1));

    ripple_carry_adder #(
        .width (xlen)
    ) u_adder (
        .i_a    (r_hi),
        .i_b    (r_mcand),
        .i_cin  (1'b0),
        .o_sum  (w_add_sum),
        .o_cout (w_add_cout)
    );

    assign w_sum_sel  = r_lo[0] ? w_add_sum : r_hi;
    assign w_cout_sel = r_lo[0] & w_add_cout;

    // {carry, sum, lo} >> 1; the single-bit case has no lo bits left to shift down.
    if (xlen == 1) begin : g_shift_one
        assign w_hi_next = w_cout_sel;
        assign w_lo_next = w_sum_sel;
    end else begin : g_shift_n
        assign w_hi_next = {w_cout_sel, w_sum_sel[xlen-1:1]};
        assign w_lo_next = {w_sum_sel[0], r_lo[xlen-1:1]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_next = w_zero ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_last) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        ready = 1'b0;
        done  = 1'b0;
        case (r_state)
            ST_IDLE: ready = 1'b1;
            ST_DONE: done  = 1'b1;
            default: begin
                ready = 1'b0;
                done  = 1'b0;
            end
        endcase
    end

    // Datapath: the product register keeps its value through IDLE until the next accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mcand <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_cnt   <= '0;
        end else if (w_accept) begin
            r_mcand <= a;
            r_hi    <= '0;
            r_lo    <= w_zero ? '0 : b;
            r_cnt   <= '0;
        end else if (r_state == ST_RUN) begin
            r_hi    <= w_hi_next;
            r_lo    <= w_lo_next;
            r_cnt   <= r_cnt + CW'(1);
        end
    end

    assign product = {r_hi, r_lo};

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed self-checking bench for shift_add_multiplier at xlen=4.
// Honours MULT_ZERO_SKIP_EN when computing expected zero-operand latency.

module tb_shift_add_multiplier;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] a;
    logic [3:0] b;
    logic       ready;
    logic       done;
    logic [7:0] product;

    int checks;
    int failures;

    shift_add_multiplier #(
        .xlen (4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .ready   (ready),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef MULT_ZERO_SKIP_EN
    localparam int ZERO_LAT = 0;
`else
    localparam int ZERO_LAT = 4;
`endif

    // Issue one multiply from IDLE. lat = edges after the accept edge until done is seen (-1 on timeout).
    task automatic run_op(input logic [3:0] ia, input logic [3:0] ib, input bit hold_start,
                          output int lat, output logic [7:0] prod);
        a     = ia;
        b     = ib;
        start = 1'b1;
        lat   = -1;
        prod  = 'x;
        for (int k = 0; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (k == 0 && !hold_start) start = 1'b0;
            if (done) begin
                lat  = k;
                prod = product;
                break;
            end
        end
        if (!hold_start) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b1;
        a     = 4'd3;
        b     = 4'd3;
        repeat (2) @(posedge clk);
        #1;
        rst   = 1'b0;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", ready); end
        checks++;
        if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
        checks++;
        if (product !== 8'd0) begin failures++; $display("FAIL reset_product got=%0d exp=0", product); end
        $display("reset: ready=%b done=%b product=%0d", ready, done, product);
    endtask

    task automatic test_basic();
        logic [3:0] va [5] = '{4'd3, 4'd15, 4'd8, 4'd7, 4'd13};
        logic [3:0] vb [5] = '{4'd5, 4'd1,  4'd8, 4'd9, 4'd11};
        logic [7:0] ve [5] = '{8'd15, 8'd15, 8'd64, 8'd63, 8'd143};
        int lat;
        logic [7:0] prod;
        for (int i = 0; i < 5; i++) begin
            run_op(va[i], vb[i], 1'b0, lat, prod);
            checks++;
            if (lat !== 4) begin failures++; $display("FAIL basic_latency %0dx%0d got=%0d exp=4", va[i], vb[i], lat); end
            checks++;
            if (prod !== ve[i]) begin failures++; $display("FAIL basic_product %0dx%0d got=%0d exp=%0d", va[i], vb[i], prod, ve[i]); end
            checks++;
            if (ready !== 1'b1 || done !== 1'b0) begin
                failures++; $display("FAIL basic_after_done ready=%b done=%b exp ready=1 done=0", ready, done);
            end
            checks++;
            if (product !== ve[i]) begin failures++; $display("FAIL basic_hold got=%0d exp=%0d", product, ve[i]); end
            $display("mul %0dx%0d: latency=%0d product=%0d", va[i], vb[i], lat, prod);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        int gap;
        logic [7:0] prod;
        bit idle_ok;
        run_op(4'd15, 4'd15, 1'b1, lat, prod);
        checks++;
        if (lat !== 4) begin failures++; $display("FAIL carry_latency got=%0d exp=4", lat); end
        checks++;
        if (prod !== 8'd225) begin failures++; $display("FAIL carry_product got=%0d exp=225", prod); end
        $display("mul 15x15: latency=%0d product=%0d", lat, prod);
        a       = 4'd9;
        b       = 4'd14;
        gap     = -1;
        idle_ok = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) idle_ok = (ready === 1'b1) && (done === 1'b0);
            if (done) begin
                gap = k;
                break;
            end
        end
        start = 1'b0;
        checks++;
        if (!idle_ok) begin failures++; $display("FAIL b2b_idle_cycle ready/done not 1/0 after first done"); end
        checks++;
        if (gap !== 6) begin failures++; $display("FAIL b2b_gap got=%0d exp=6", gap); end
        checks++;
        if (product !== 8'd126) begin failures++; $display("FAIL b2b_product got=%0d exp=126", product); end
        $display("mul 9x14 back-to-back: gap=%0d product=%0d", gap, product);
        @(posedge clk);
        #1;
    endtask

    task automatic test_zero();
        int lat;
        logic [7:0] prod;
        run_op(4'd0, 4'd7, 1'b0, lat, prod);
        checks++;
        if (lat !== ZERO_LAT) begin failures++; $display("FAIL zero_a_latency got=%0d exp=%0d", lat, ZERO_LAT); end
        checks++;
        if (prod !== 8'd0) begin failures++; $display("FAIL zero_a_product got=%0d exp=0", prod); end
        $display("mul 0x7: latency=%0d product=%0d", lat, prod);
        run_op(4'd9, 4'd0, 1'b0, lat, prod);
        checks++;
        if (lat !== ZERO_LAT) begin failures++; $display("FAIL zero_b_latency got=%0d exp=%0d", lat, ZERO_LAT); end
        checks++;
        if (prod !== 8'd0) begin failures++; $display("FAIL zero_b_product got=%0d exp=0", prod); end
        $display("mul 9x0: latency=%0d product=%0d", lat, prod);
    endtask

    task automatic test_ignore_inputs();
        int lat;
        bit busy_ok;
        a       = 4'd6;
        b       = 4'd7;
        start   = 1'b1;
        lat     = -1;
        busy_ok = 1'b1;
        @(posedge clk);
        #1;
        a = 4'd1;
        b = 4'd1;
        for (int k = 1; k <= 20; k++) begin
            start = ~start;
            @(posedge clk);
            #1;
            if (done) begin
                lat   = k;
                start = 1'b0;
                break;
            end
            if (ready !== 1'b0) busy_ok = 1'b0;
        end
        start = 1'b0;
        checks++;
        if (!busy_ok) begin failures++; $display("FAIL ignore_ready ready high during RUN"); end
        checks++;
        if (lat !== 4) begin failures++; $display("FAIL ignore_latency got=%0d exp=4", lat); end
        checks++;
        if (product !== 8'd42) begin failures++; $display("FAIL ignore_product got=%0d exp=42", product); end
        $display("mul 6x7 with noisy inputs: latency=%0d product=%0d", lat, product);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_abort();
        int lat;
        int done_seen;
        logic [7:0] prod;
        a     = 4'd5;
        b     = 4'd5;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if (ready !== 1'b1 || done !== 1'b0) begin
            failures++; $display("FAIL abort_state ready=%b done=%b exp ready=1 done=0", ready, done);
        end
        checks++;
        if (product !== 8'd0) begin failures++; $display("FAIL abort_product got=%0d exp=0", product); end
        done_seen = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            if (done) done_seen++;
        end
        checks++;
        if (done_seen !== 0) begin failures++; $display("FAIL abort_no_done got=%0d pulses exp=0", done_seen); end
        $display("abort 5x5: done_pulses=%0d product=%0d", done_seen, product);
        run_op(4'd2, 4'd3, 1'b0, lat, prod);
        checks++;
        if (lat !== 4) begin failures++; $display("FAIL abort_next_latency got=%0d exp=4", lat); end
        checks++;
        if (prod !== 8'd6) begin failures++; $display("FAIL abort_next_product got=%0d exp=6", prod); end
        $display("mul 2x3 after abort: latency=%0d product=%0d", lat, prod);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        start    = 1'b0;
        a        = '0;
        b        = '0;
        test_reset();
        test_basic();
        test_back_to_back();
        test_zero();
        test_ignore_inputs();
        test_reset_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
